dm_responder: RTL
=================

Name: dm_responder

Overview:
- Handshaked data-memory responder for the multi-cycle MIPS datapath; it is the memory end of the CPU's load/store protocol.
- Accepts one request at a time from the controller side (load/store, word or byte).
- Inserts a configurable number of wait states, performs the access on an internal byte-addressed 1 KB array, and returns a one-cycle acknowledge with read data.
- Byte stores are done internally as read-modify-write, so the datapath no longer needs external sb/lb merge logic.

Parameters:
- WAIT_CYCLES, 2, number of wait-state cycles inserted between request acceptance and the array access (legal range 0..15).
- DEPTH_WORDS, 256, number of 32-bit words in the array; address width is fixed at 10 bits (byte address).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; captured with req.
- byte_op  input  1  1 = byte access (lb/sb), 0 = word access (lw/sw); captured with req.
- addr  input  10  byte address; captured with req.
- wdata  input  32  store data; for byte stores only bits [7:0] are used; captured with req.
- busy  output  1  high from the cycle after acceptance through the ack cycle.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  load result; valid when ack=1 and the access was a load, and held until the next ack.
- err  output  1  valid with ack; high for a word access with addr[1:0] != 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state <= IDLE; busy, ack, err, rdata <= 0; wait counter <= 0.
  - Array contents are not cleared.
  - Reset wins over every other event, including mid-transaction; an interrupted store does not update the array if reset arrives before ACCESS.
- State machine: IDLE, WAIT, ACCESS, MERGE, RESP.
- IDLE:
  - If req=1, latch we/byte_op/addr/wdata and set busy=1.
  - Go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - Go to ACCESS when the counter is 0. WAIT therefore lasts exactly WAIT_CYCLES cycles.
- ACCESS:
  - Word index is addr[9:2]. Low address bits are ignored for word accesses, which also set err=1.
  - Load word: rdata <= mem[idx]; go to RESP.
  - Load byte: select byte addr[1:0], little-endian (0 = bits [7:0]); sign-extend to 32 bits into rdata; go to RESP.
  - Store word: mem[idx] <= wdata; go to RESP.
  - Store byte: latch mem[idx] into the merge buffer; go to MERGE.
- MERGE (store byte only): replace the byte lane selected by addr[1:0] with wdata[7:0], write the word back to mem[idx], go to RESP.
- RESP: ack=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- Latency, counted from the accepting edge T: ack is high in cycle T+WAIT_CYCLES+2; byte stores add 1 cycle.
- Request overlap:
  - req while busy is ignored; it is neither queued nor an error.
  - req held high through RESP is re-accepted in the first IDLE cycle. Back-to-back throughput is one request per (latency+1) cycles.
  - Input changes after acceptance have no effect.
- Stores never change rdata; err=0 for all byte accesses.
- Array is a plain register array (synchronous write, read registered into rdata) so a bench can preload it by hierarchical $readmemh.

Decomposition:
- Shared package `dm_pkg`: state encoding constants (IDLE=0, WAIT=1, ACCESS=2, MERGE=3, RESP=4), address width 10, word index width 8.
- One natural sub-module, `dm_byte_lane`, combinational: byte select with sign-extend for loads, and byte-lane merge for stores, keyed by addr[1:0].
- FSM, counter and array stay in the top module.

Test Plan:
- Reset then store word: WAIT_CYCLES=2, req at T with we=1, byte_op=0, addr=0x010, wdata=0xDEADBEEF -> ack only at T+4, err=0. A following load from 0x010 -> rdata=0xDEADBEEF at its ack.
- Byte load sign extension: mem word 4 = 0x80FF7F01; lb at 0x013 -> rdata=0xFFFFFF80; lb at 0x012 -> 0xFFFFFFFF; lb at 0x010 -> 0x00000001.
- Byte store RMW: mem word 4 = 0x11223344; sb 0xAB at 0x011 -> ack at T+5; a word load then returns 0x1122AB44.
- Misaligned word plus WAIT_CYCLES=0: lw at 0x012 with word 4 = 0xCAFEF00D -> ack at T+2 with err=1 and rdata=0xCAFEF00D.
- Overlap: req held high continuously for two loads -> exactly two ack pulses, separated by latency+1 cycles; mid-transaction changes to addr/wdata are ignored.
- Reset mid-operation: sw to 0x020 with 0x12345678, rst asserted during WAIT -> no ack, busy=0 next cycle, word 8 unchanged; the next request completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM states, address
// geometry and the word-alignment rule.
package dm_pkg;

  localparam int ADDR_W = 10;
  localparam int IDX_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_MERGE  = 3'd3,
    S_RESP   = 3'd4
  } dm_state_e;

  function automatic logic word_misaligned(input logic byte_op, input logic [1:0] lane);
    return !byte_op && (lane != 2'b00);
  endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Byte-lane helper: little-endian byte select with sign extension for loads,
// and single-lane replacement for read-modify-write byte stores.
module dm_byte_lane
  import dm_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0] sel_byte;

  // NOTE: every combinational output gets a default before the case, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    sel_byte = word_i[7:0];
    merge_o  = word_i;
    case (lane_i)
      2'd0: begin sel_byte = word_i[7:0];   merge_o[7:0]   = byte_i; end
      2'd1: begin sel_byte = word_i[15:8];  merge_o[15:8]  = byte_i; end
      2'd2: begin sel_byte = word_i[23:16]; merge_o[23:16] = byte_i; end
      default: begin sel_byte = word_i[31:24]; merge_o[31:24] = byte_i; end
    endcase
    load_o = {{24{sel_byte[7]}}, sel_byte};
  end

endmodule

// File: rtl/dm_responder.sv
// Handshaked data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, accesses a byte-addressed word array and pulses ack.
module dm_responder
  import dm_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_word, lane_word, lane_load, lane_merge;
  logic        mem_we;
  logic [31:0] mem_wdata;

  assign idx       = addr_q[ADDR_W-1:2];
  assign rd_word   = mem_q[idx];
  assign lane_word = (state_q == S_MERGE) ? merge_q : rd_word;

  dm_byte_lane u_lane (
    .lane_i  (addr_q[1:0]),
    .word_i  (lane_word),
    .byte_i  (wdata_q[7:0]),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          byte_d  = byte_op;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        err_d = word_misaligned(byte_q, addr_q[1:0]);
        if (we_q && byte_q) begin
          merge_d = rd_word;
          state_d = S_MERGE;
        end else begin
          state_d = S_RESP;
          if (we_q) mem_we  = 1'b1;
          else      rdata_d = byte_q ? lane_load : rd_word;
        end
      end
      S_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = lane_merge;
        state_d   = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rst and it
  // maps onto plain storage.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[idx] <= mem_wdata;
  end

  assign busy  = (state_q != S_IDLE);
  assign ack   = (state_q == S_RESP);
  assign err   = ack & err_q;
  assign rdata = rdata_q;

endmodule
